// File: rtl/hilo_if.sv
// Request/result bundle between EX and the HI/LO multiply-divide unit.
//   master : drives start/op/rs_in/rt_in/cancel, observes hilo_out/busy/done
//   slave  : the hilo_unit side
interface hilo_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_W-1:0]     rs_in;
    logic [DATA_W-1:0]     rt_in;
    logic                  cancel;
    logic [2*DATA_W-1:0]   hilo_out;
    logic                  busy;
    logic                  done;

    modport master (
        output start, op, rs_in, rt_in, cancel,
        input  hilo_out, busy, done
    );

    modport slave (
        input  start, op, rs_in, rt_in, cancel,
        output hilo_out, busy, done
    );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO owner: single-cycle-latency multiply, 32-step restoring divide, MTHI/MTLO.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : hilo_if slave (start/op/rs_in/rt_in/cancel in; hilo_out/busy/done out)
module hilo_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    hilo_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned PRD_W = 2 * DATA_W;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  op_a_q, op_a_d;   // multiplicand, or dividend shifting into quotient
    logic [DATA_W-1:0]  op_b_q, op_b_d;   // multiplier, or divisor magnitude
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic               sgn_q, sgn_d;     // signed multiply
    logic               neg_q_q, neg_q_d; // negate quotient at FIX
    logic               neg_r_q, neg_r_d; // negate remainder at FIX
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept;
    logic               op_signed;
    logic [PRD_W-1:0]   ext_a, ext_b, prod;
    logic [DATA_W:0]    trial;
    logic               qbit;

    assign accept    = bus.start && !bus.cancel;
    assign op_signed = (bus.op == OP_DIV);

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then correct for both.
    assign ext_a = sgn_q ? {{DATA_W{op_a_q[DATA_W-1]}}, op_a_q} : {{DATA_W{1'b0}}, op_a_q};
    assign ext_b = sgn_q ? {{DATA_W{op_b_q[DATA_W-1]}}, op_b_q} : {{DATA_W{1'b0}}, op_b_q};
    assign prod  = ext_a * ext_b;

    // Restoring step: shift the dividend MSB into the remainder, subtract if it fits.
    assign trial = {rem_q, op_a_q[DATA_W-1]} - {1'b0, op_b_q};
    assign qbit  = !trial[DATA_W];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MULT || bus.op == OP_MULTU) begin
                        state_d = MUL;
                    end else if ((bus.op == OP_DIV || bus.op == OP_DIVU) && bus.rt_in != '0) begin
                        state_d = DIV;
                    end
                end
            end
            MUL:     state_d = IDLE;
            DIV:     if (bus.cancel) state_d = IDLE;
                     else if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output next-values
    always_comb begin
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.rs_in;
                        OP_MTLO: lo_d = bus.rs_in;
                        OP_MULT, OP_MULTU: begin
                            op_a_d = bus.rs_in;
                            op_b_d = bus.rt_in;
                            sgn_d  = (bus.op == OP_MULT);
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.rt_in == '0) begin
                                hi_d   = bus.rs_in;
                                lo_d   = '1;
                                done_d = 1'b1;
                            end else begin
                                op_a_d  = (op_signed && bus.rs_in[DATA_W-1]) ? -bus.rs_in : bus.rs_in;
                                op_b_d  = (op_signed && bus.rt_in[DATA_W-1]) ? -bus.rt_in : bus.rt_in;
                                neg_q_d = op_signed && (bus.rs_in[DATA_W-1] ^ bus.rt_in[DATA_W-1]);
                                neg_r_d = op_signed && bus.rs_in[DATA_W-1];
                                rem_d   = '0;
                                cnt_d   = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (!bus.cancel) begin
                    {hi_d, lo_d} = prod;
                    done_d       = 1'b1;
                end
            end
            DIV: begin
                if (!bus.cancel) begin
                    rem_d  = qbit ? trial[DATA_W-1:0] : {rem_q[DATA_W-2:0], op_a_q[DATA_W-1]};
                    op_a_d = {op_a_q[DATA_W-2:0], qbit};
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                if (!bus.cancel) begin
                    lo_d   = neg_q_q ? -op_a_q : op_a_q;
                    hi_d   = neg_r_q ? -rem_q : rem_q;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            rem_q   <= '0;
            sgn_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.hilo_out = {hi_q, lo_q};
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit.
module tb_hilo_unit;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    hilo_if #(.DATA_W(32)) bus ();

    hilo_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs_in = rs;
        bus.rt_in = rt;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 3'b000;
        bus.rs_in  = '0;
        bus.rt_in  = '0;
        bus.cancel = 1'b0;
        tick();
        tick();
        checks++; if (bus.hilo_out !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h want %h", bus.hilo_out, 64'h0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        issue(3'b000, 32'hFFFFFFFD, 32'd5);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b want 1", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_early: got %b want 0", bus.done); end
        tick();
        checks++; if (bus.hilo_out !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL mult_hilo: got %h want %h", bus.hilo_out, 64'hFFFFFFFF_FFFFFFF1); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_drop: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL mult_done: got %b want 1", bus.done); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_once: got %b want 0", bus.done); end
    endtask

    task automatic test_multu_mtlo();
        issue(3'b001, 32'hFFFFFFFF, 32'd2);
        tick();
        checks++; if (bus.hilo_out !== 64'h00000001_FFFFFFFE) begin errors++; $display("FAIL multu_hilo: got %h want %h", bus.hilo_out, 64'h00000001_FFFFFFFE); end
        issue(3'b101, 32'h12345678, 32'd0);
        checks++; if (bus.hilo_out !== 64'h00000001_12345678) begin errors++; $display("FAIL mtlo_hilo: got %h want %h", bus.hilo_out, 64'h00000001_12345678); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mtlo_done: got %b want 0", bus.done); end
    endtask

    task automatic test_div_signed();
        int n;
        issue(3'b010, 32'hFFFFFFF9, 32'd2);
        n = 0;
        while (bus.busy && n < 100) begin n++; tick(); end
        checks++; if (n != 33) begin errors++; $display("FAIL div_busy_cycles: got %0d want 33", n); end
        checks++; if (bus.hilo_out !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_hilo: got %h want %h", bus.hilo_out, 64'hFFFFFFFF_FFFFFFFD); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL div_done: got %b want 1", bus.done); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(3'b011, 32'd100, 32'd7);
        for (int i = 0; i < 5; i++) tick();
        issue(3'b000, 32'd3, 32'd3);
        n = 0;
        while (bus.busy && n < 100) begin n++; tick(); end
        checks++; if (n >= 100) begin errors++; $display("FAIL divu_timeout: got %0d cycles want <100", n); end
        checks++; if (bus.hilo_out !== 64'h00000002_0000000E) begin errors++; $display("FAIL divu_hilo: got %h want %h", bus.hilo_out, 64'h00000002_0000000E); end
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL divu_no_queue_busy: got %b want 0", bus.busy); end
        checks++; if (bus.hilo_out !== 64'h00000002_0000000E) begin errors++; $display("FAIL divu_no_queue_hilo: got %h want %h", bus.hilo_out, 64'h00000002_0000000E); end
    endtask

    task automatic test_div_corners();
        int n;
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        n = 0;
        while (bus.busy && n < 100) begin n++; tick(); end
        checks++; if (bus.hilo_out !== 64'h00000000_80000000) begin errors++; $display("FAIL div_ovf_hilo: got %h want %h", bus.hilo_out, 64'h00000000_80000000); end
        tick();
        issue(3'b011, 32'd9, 32'd0);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL div0_busy: got %b want 0", bus.busy); end
        checks++; if (bus.hilo_out !== 64'h00000009_FFFFFFFF) begin errors++; $display("FAIL div0_hilo: got %h want %h", bus.hilo_out, 64'h00000009_FFFFFFFF); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL div0_done: got %b want 1", bus.done); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL div0_done_once: got %b want 0", bus.done); end
    endtask

    task automatic test_invalid_and_idle_cancel();
        issue(3'b110, 32'h11111111, 32'h2);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL invalid_busy: got %b want 0", bus.busy); end
        checks++; if (bus.hilo_out !== 64'h00000009_FFFFFFFF) begin errors++; $display("FAIL invalid_hilo: got %h want %h", bus.hilo_out, 64'h00000009_FFFFFFFF); end
        bus.cancel = 1'b1;
        issue(3'b101, 32'h0, 32'h0);
        bus.cancel = 1'b0;
        checks++; if (bus.hilo_out !== 64'h00000009_FFFFFFFF) begin errors++; $display("FAIL idle_cancel_hilo: got %h want %h", bus.hilo_out, 64'h00000009_FFFFFFFF); end
    endtask

    task automatic test_cancel();
        issue(3'b100, 32'hAAAAAAAA, 32'h0);
        issue(3'b101, 32'h55555555, 32'h0);
        checks++; if (bus.hilo_out !== 64'hAAAAAAAA_55555555) begin errors++; $display("FAIL preload_hilo: got %h want %h", bus.hilo_out, 64'hAAAAAAAA_55555555); end
        issue(3'b010, 32'd50, 32'd3);
        for (int i = 0; i < 10; i++) tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL cancel_busy_before: got %b want 1", bus.busy); end
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b want 0", bus.busy); end
        checks++; if (bus.hilo_out !== 64'hAAAAAAAA_55555555) begin errors++; $display("FAIL cancel_hilo: got %h want %h", bus.hilo_out, 64'hAAAAAAAA_55555555); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL cancel_done: got %b want 0", bus.done); end
        for (int i = 0; i < 40; i++) tick();
        checks++; if (bus.hilo_out !== 64'hAAAAAAAA_55555555) begin errors++; $display("FAIL cancel_hilo_later: got %h want %h", bus.hilo_out, 64'hAAAAAAAA_55555555); end
    endtask

    task automatic test_reset_mid();
        int n;
        issue(3'b010, 32'd50, 32'd3);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.hilo_out !== 64'h0) begin errors++; $display("FAIL rst_mid_hilo: got %h want %h", bus.hilo_out, 64'h0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
        tick();
        rst_n = 1'b1;
        tick();
        issue(3'b010, 32'd50, 32'd3);
        n = 0;
        while (bus.busy && n < 100) begin n++; tick(); end
        checks++; if (bus.hilo_out !== 64'h00000002_00000010) begin errors++; $display("FAIL div_after_rst: got %h want %h", bus.hilo_out, 64'h00000002_00000010); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mult();
        test_multu_mtlo();
        test_div_signed();
        test_back_to_back();
        test_div_corners();
        test_invalid_and_idle_cancel();
        test_cancel();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Multiply/divide execution unit that owns the HI/LO register pair.
- Its 64-bit output is the hilo_in source consumed by the register-file writeback select for MFHI/MFLO.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and computes the product or quotient. Division uses a radix-2 restoring iterative divider.
- Raises busy so the hazard unit can stall MFHI/MFLO and any new mul/div.

Parameters:
- DATA_W, 32, operand width. Only 32 is supported. HI/LO are DATA_W each, and the divide iterates DATA_W steps.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  op request valid this cycle
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are no-ops
- rs_in  input  32  operand A / dividend / MTHI-MTLO data
- rt_in  input  32  operand B / divisor
- cancel  input  1  pipeline flush (exception); aborts the in-flight op
- hilo_out  output  64  {HI,LO}, registered
- busy  output  1  op in flight; start is ignored
- done  output  1  one-cycle pulse when hilo_out has just been updated by MULT/MULTU/DIV/DIVU

Behaviour:
- Reset (async, rst_n=0): state IDLE, hilo_out=0, busy=0, done=0, iteration counter=0, operand/partial registers=0. Reset mid-operation discards the op.
- States: IDLE, MUL, DIV, FIX.
- Accept rule: start=1 && state==IDLE && cancel=0 at a rising edge. While busy, start is ignored with no queuing.
- MTHI/MTLO: HI (or LO) <= rs_in at the accept edge. The other half is unchanged, state stays IDLE, busy stays 0, done stays 0.
- MULT/MULTU, accept edge: latch operands, go to MUL, busy=1.
  - Next edge: hilo_out <= 64-bit product (signed for MULT, unsigned for MULTU), go to IDLE.
  - busy is high for exactly 1 cycle. done=1 in the cycle after the write.
- DIV/DIVU with rt_in==0: accept edge writes HI <= rs_in and LO <= 32'hFFFFFFFF, stays IDLE, done pulses next cycle, busy stays 0.
- DIV/DIVU with rt_in!=0, accept edge:
  - Latch |rs|, |rt| (DIV) or the raw values (DIVU), plus sign flags. Clear remainder; counter=0; go to DIV; busy=1.
  - DIV state: one restoring step per edge, shifting the quotient MSB-first. On the edge where counter reaches DATA_W-1, go to FIX.
  - FIX edge, signed DIV:
    - Quotient is negated if the operand signs differ.
    - Remainder takes the dividend's sign.
  - FIX edge, common: LO <= quotient, HI <= remainder, go to IDLE.
  - busy is high for DATA_W+1 = 33 cycles. done pulses in the following cycle.
- Signed corner case: 0x80000000 / -1 gives LO=0x80000000, HI=0 (truncating wrap, no trap).
- cancel=1 in MUL/DIV/FIX: the next edge returns to IDLE with hilo_out unchanged and done=0; busy drops after that edge.
- cancel=1 in IDLE: any start in the same cycle is suppressed.
- Writes occur only in IDLE (MT*) or MUL/FIX, so there is no simultaneous MT* and result write.
- busy=1 exactly when state != IDLE.
- hilo_out changes only on clock edges; there is no combinational path from inputs.
- Invalid op with start in IDLE: no state change.

Test Plan:
- MULT, rs=0xFFFFFFFD (-3), rt=5 -> after 1 busy cycle, hilo_out=0xFFFFFFFF_FFFFFFF1 and done pulses once.
- MULTU, rs=0xFFFFFFFF, rt=2 -> hilo_out=0x00000001_FFFFFFFE. Then MTLO rs=0x12345678 -> hilo_out=0x00000001_12345678 next cycle, busy=0 throughout.
- DIV, rs=-7 (0xFFFFFFF9), rt=2 -> busy high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, rs=100, rt=7 -> LO=0x0000000E, HI=0x00000002. A second start mid-divide is ignored and the result is unchanged.
- DIV, rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU, rs=9, rt=0 -> HI=9, LO=0xFFFFFFFF, busy never asserted.
- Preload hilo_out=0xAAAA_5555 via MTHI/MTLO, start DIV 50/3, then either:
  - assert cancel at iteration 10 -> IDLE next edge, hilo unchanged, no done;
  - or, in a separate run, drop rst_n mid-divide -> hilo_out=0, busy=0 immediately.
